multicycle_rtype_sequencer: RTL and testbench
=============================================

// Module: multicycle_rtype_sequencer
// PURPOSE
// - Multi-cycle FSM that sequences the R-type datapath through FETCH, DECODE, EXECUTE and WRITEBACK.
// - Drives the instruction-memory request handshake, the IR load, the ALU operation, the regfile write and the PC advance.
// - Detects illegal encodings and instruction-fetch timeouts, then halts.
// - Sits beside the datapath: takes the latched IR, returns control strobes.
// PARAMETERS
// - ADDR_DATA_WIDTH  32   instruction width.
// - IMEM_TIMEOUT     16   maximum FETCH wait cycles for imem_valid before the ERROR state.
// - CNT_WIDTH        32   width of the retired-instruction counter.
// PORTS
// - clk                   in   1   single clock; all state changes on the rising edge.
// - reset                 in   1   asynchronous, active-low reset.
// - run                   in   1   1 = execute; 0 = stop at the next instruction boundary.
// - imem_valid            in   1   instruction memory has the requested word this cycle.
// - ir                    in   32  latched instruction register from the datapath.
// - imem_req              out  1   fetch request at the current PC.
// - ir_load               out  1   datapath captures the imem word into IR.
// - alu_op                out  4   ALU operation code (alu_op_e).
// - regfile_write_enable  out  1   write the ALU result to rd.
// - pc_en                 out  1   PC <= PC + 4.
// - illegal_instr         out  1   sticky: an illegal instruction was decoded.
// - fetch_timeout         out  1   sticky: imem_valid did not arrive in time.
// - halted                out  1   FSM is in ERROR.
// - instr_count           out  CNT_WIDTH  retired instructions, saturating.
// BEHAVIOUR
// - Reset (reset == 0, async):
//   - state = IDLE; every output is 0; alu_op = ALU_ADD; counters and sticky flags are cleared.
//   - Applies immediately from any state, including mid-fetch or mid-writeback; no partial write completes.
// - Outputs are Moore decodes of state plus registered alu_op, except ir_load = (state==FETCH) && imem_valid.
// - IDLE: all strobes 0. run=1 -> FETCH.
// - FETCH:
//   - imem_req = 1.
//   - imem_valid = 1 -> ir_load = 1 that cycle -> DECODE; wait counter cleared.
//   - Otherwise the wait counter increments. When it reaches IMEM_TIMEOUT-1 with no imem_valid -> ERROR, fetch_timeout = 1.
//   - imem_valid arriving in the same cycle the limit is hit wins: the FSM goes to DECODE.
// - DECODE (uses ir):
//   - Legal when opcode == 7'b0110011 and one of:
//     - funct7 == 7'b0000000 (any funct3);
//     - funct7 == 7'b0100000 and funct3 is 000 or 101.
//   - Legal -> alu_op register loaded -> EXECUTE. Illegal -> ERROR with illegal_instr = 1; no regfile write, no PC advance.
// - alu_op map:
//   - 0000000: f3 000 ADD=0, 001 SLL=2, 010 SLT=3, 011 SLTU=4, 100 XOR=5, 101 SRL=6, 110 OR=8, 111 AND=9.
//   - 0100000: f3 000 SUB=1, 101 SRA=7.
// - EXECUTE: alu_op held; strobes 0; 1 cycle -> WRITEBACK.
// - WRITEBACK:
//   - pc_en = 1.
//   - regfile_write_enable = 1 unless ir[11:7] == 0 (a write to x0 is suppressed but the instruction still retires).
//   - instr_count += 1; holds at all-ones.
//   - Next state: run = 1 -> FETCH; run = 0 -> IDLE.
// - run deasserting mid-instruction never aborts it; it is sampled only in IDLE and WRITEBACK.
// - ERROR: halted = 1; every strobe 0; only reset exits.
// - Latency: 4 cycles per instruction with zero-wait imem (imem_valid in the first FETCH cycle); each wait cycle adds 1.
// STRUCTURE
// - Package rtype_ctrl_pkg holds:
//   - state_e {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, ERROR};
//   - alu_op_e (4-bit encodings above);
//   - OPC_RTYPE, F7_BASE, F7_ALT constants.
// - Sub-module rtype_decoder: combinational; (opcode, funct3, funct7) -> {legal, alu_op}; shared with the single-cycle controller.
// - Top level holds the FSM, fetch wait counter, instr_count and sticky flags.
// TESTING
// - Reset, run=1, imem_valid held 1, ir=0x002081B3 (add x3,x1,x2):
//   - states IDLE,FETCH,DECODE,EXECUTE,WRITEBACK;
//   - alu_op=0; write_enable and pc_en pulse once; instr_count=1.
// - ir=0x407302B3 (sub x5,x6,x7) -> alu_op=1 in EXECUTE/WRITEBACK. ir=0x00208033 (add x0) -> pc_en=1, regfile_write_enable=0, count+1.
// - ir=0x00000013 (opcode 0010011) -> ERROR after DECODE; illegal_instr=1, halted=1; no pc_en or write; stays until reset.
// - ir=0x40209033 (funct7 0100000, funct3 001) -> illegal, as above.
// - imem_valid=0 in FETCH:
//   - held low for 15 cycles -> ERROR, fetch_timeout=1.
//   - rising on wait cycle 14 -> DECODE, no error.
// - Reset pulsed low in WRITEBACK -> outputs 0 asynchronously, state IDLE, count 0.
// - run dropped in EXECUTE -> instruction completes, FSM parks in IDLE.

Source files
------------

// File: rtl/rtype_ctrl_pkg.sv
// Shared types and encoding constants for the R-type control path
// (multi-cycle sequencer and the single-cycle controller).
package rtype_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        ERROR
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decode: opcode/funct3/funct7 to legality and ALU operation.
module rtype_decoder
    import rtype_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       legal,
    output alu_op_e    alu_op
);

    always_comb begin
        legal  = 1'b0;
        alu_op = ALU_ADD;
        if (opcode == OPC_RTYPE) begin
            if (funct7 == F7_BASE) begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end else if (funct7 == F7_ALT) begin
                // Only SUB and SRA exist in the alternate funct7 space.
                case (funct3)
                    3'b000: begin
                        legal  = 1'b1;
                        alu_op = ALU_SUB;
                    end
                    3'b101: begin
                        legal  = 1'b1;
                        alu_op = ALU_SRA;
                    end
                    default: begin
                        legal  = 1'b0;
                        alu_op = ALU_ADD;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multicycle_rtype_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the R-type datapath,
// with fetch timeout and illegal-instruction halting.
module multicycle_rtype_sequencer
    import rtype_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_DATA_WIDTH = 32,
    parameter int unsigned IMEM_TIMEOUT    = 16,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       imem_valid,
    input  logic [ADDR_DATA_WIDTH-1:0] ir,
    output logic                       imem_req,
    output logic                       ir_load,
    output logic [3:0]                 alu_op,
    output logic                       regfile_write_enable,
    output logic                       pc_en,
    output logic                       illegal_instr,
    output logic                       fetch_timeout,
    output logic                       halted,
    output logic [CNT_WIDTH-1:0]       instr_count
);

    localparam int unsigned WAIT_W = (IMEM_TIMEOUT > 2) ? $clog2(IMEM_TIMEOUT) : 1;
    // The counter value seen in the last allowed FETCH cycle; missing valid there times out.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(IMEM_TIMEOUT - 2);

    state_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    alu_op_e           alu_op_q;
    logic              dec_legal;
    alu_op_e           dec_op;
    logic              unused_ir_bits;

    rtype_decoder u_decoder (
        .opcode (ir[6:0]),
        .funct3 (ir[14:12]),
        .funct7 (ir[31:25]),
        .legal  (dec_legal),
        .alu_op (dec_op)
    );

    assign unused_ir_bits = ^ir[24:15];
    assign ir_load        = (state == FETCH) && imem_valid;
    assign alu_op         = alu_op_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            wait_cnt             <= '0;
            alu_op_q             <= ALU_ADD;
            imem_req             <= 1'b0;
            regfile_write_enable <= 1'b0;
            pc_en                <= 1'b0;
            illegal_instr        <= 1'b0;
            fetch_timeout        <= 1'b0;
            halted               <= 1'b0;
            instr_count          <= '0;
        end else begin
            imem_req             <= 1'b0;
            regfile_write_enable <= 1'b0;
            pc_en                <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (imem_valid) begin
                        state    <= DECODE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state         <= ERROR;
                        fetch_timeout <= 1'b1;
                        halted        <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        alu_op_q <= dec_op;
                        state    <= EXECUTE;
                    end else begin
                        state         <= ERROR;
                        illegal_instr <= 1'b1;
                        halted        <= 1'b1;
                    end
                end
                EXECUTE: begin
                    // WRITEBACK strobes and the retire count are registered on entry.
                    state                <= WRITEBACK;
                    pc_en                <= 1'b1;
                    regfile_write_enable <= (ir[11:7] != 5'd0);
                    if (instr_count != '1) begin
                        instr_count <= instr_count + CNT_WIDTH'(1);
                    end
                end
                WRITEBACK: begin
                    if (run) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_rtype_sequencer.sv
// Scoreboard bench: stimulus pushes expected retire/halt events, a monitor pops and compares.
module tb_multicycle_rtype_sequencer;

    localparam int K_RETIRE  = 0;
    localparam int K_ILLEGAL = 1;
    localparam int K_TIMEOUT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_valid;
    logic [31:0] ir;
    logic        imem_req;
    logic        ir_load;
    logic [3:0]  alu_op;
    logic        regfile_write_enable;
    logic        pc_en;
    logic        illegal_instr;
    logic        fetch_timeout;
    logic        halted;
    logic [31:0] instr_count;

    multicycle_rtype_sequencer #(
        .ADDR_DATA_WIDTH(32),
        .IMEM_TIMEOUT   (16),
        .CNT_WIDTH      (32)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .run                  (run),
        .imem_valid           (imem_valid),
        .ir                   (ir),
        .imem_req             (imem_req),
        .ir_load              (ir_load),
        .alu_op               (alu_op),
        .regfile_write_enable (regfile_write_enable),
        .pc_en                (pc_en),
        .illegal_instr        (illegal_instr),
        .fetch_timeout        (fetch_timeout),
        .halted               (halted),
        .instr_count          (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          op;
        int          we;
        int unsigned count;
        int unsigned lat;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    int unsigned exp_count = 0;
    int unsigned base_map[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    int unsigned cyc = 0;
    int unsigned fstart = 0;
    int unsigned loads = 0;
    logic        prev_req = 1'b0;
    logic        prev_halt = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Expected outcome from the instruction-set rules and the fetch-wait budget.
    function automatic exp_t ref_model(input logic [31:0] iv, input int unsigned waits);
        exp_t       e;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        opc    = iv[6:0];
        f3     = iv[14:12];
        f7     = iv[31:25];
        e.kind = K_RETIRE;
        e.op   = 0;
        e.we   = (iv[11:7] != 5'd0) ? 1 : 0;
        e.lat  = waits + 4;
        e.count = 0;
        if (waits >= 15) e.kind = K_TIMEOUT;
        else if (opc != 7'h33) e.kind = K_ILLEGAL;
        else if (f7 == 7'h00) e.op = int'(base_map[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = 7;
        else e.kind = K_ILLEGAL;
        return e;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [6:0]  f7;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int unsigned sel;
        sel = $urandom_range(0, 9);
        f3  = 3'($urandom);
        opc = 7'h33;
        rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        f7  = 7'h00;
        if (sel >= 6 && sel < 8) begin
            f7 = 7'h20;
            f3 = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd0;
        end else if (sel == 8) begin
            f7 = 7'h20;
        end else if (sel == 9) begin
            opc = 7'($urandom);
        end
        return {f7, 5'($urandom), 5'($urandom), f3, rd, opc};
    endfunction

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_ir_load", ir_load, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_we", regfile_write_enable, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_illegal", illegal_instr, 0);
        check("rst_timeout", fetch_timeout, 0);
        check("rst_halted", halted, 0);
        check("rst_count", instr_count, 0);
        exp_q.delete();
        exp_count = 0;
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", halted, 1);
        repeat (3) begin
            @(negedge clk);
            check("error_halted", halted, 1);
            check("error_no_req", imem_req, 0);
            check("error_no_pc_en", pc_en, 0);
            check("error_no_write", regfile_write_enable, 0);
        end
        do_reset();
    endtask

    task automatic do_instr(input logic [31:0] iv, input int unsigned waits,
                            input bit drop_run, input bit rst_wb);
        exp_t e;
        int   n;
        e = ref_model(iv, waits);
        if (e.kind == K_RETIRE) begin
            if (exp_count != 32'hFFFF_FFFF) exp_count++;
            e.count = exp_count;
        end
        exp_q.push_back(e);
        ir = iv;
        imem_valid = (waits == 0);
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            check("fetch_start", imem_req, 1);
            return;
        end
        if (waits >= 15) begin
            imem_valid = 1'b0;
            wait_halt();
            return;
        end
        repeat (waits) @(negedge clk);
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        if (e.kind != K_RETIRE) begin
            wait_halt();
            return;
        end
        @(negedge clk);
        if (drop_run) run = 1'b0;
        n = 0;
        while (!pc_en && !halted && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("retire_seen", pc_en, 1);
        if (rst_wb) begin
            do_reset();
            return;
        end
        if (drop_run) begin
            repeat (3) begin
                @(negedge clk);
                check("parked_no_req", imem_req, 0);
                check("parked_no_halt", halted, 0);
            end
            run = 1'b1;
        end
    endtask

    // Monitor: samples just after the falling edge, after stimulus updates.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset) begin
                prev_req  = 1'b0;
                prev_halt = 1'b0;
                loads     = 0;
            end else begin
                if (imem_req && !prev_req) begin
                    fstart = cyc;
                    loads  = 0;
                end
                if (ir_load) loads++;
                if (pc_en) begin
                    if (exp_q.size() == 0) check("unexpected_retire", pc_en, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("retire_kind", K_RETIRE, e.kind);
                        if (e.kind == K_RETIRE) begin
                            check("alu_op", alu_op, e.op);
                            check("write_enable", regfile_write_enable, e.we);
                            check("instr_count", instr_count, e.count);
                            check("latency", cyc - fstart + 1, e.lat);
                            check("ir_load_pulses", loads, 1);
                        end
                    end
                end
                if (halted && !prev_halt) begin
                    if (exp_q.size() == 0) check("unexpected_halt", halted, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("halt_kind", illegal_instr ? K_ILLEGAL :
                              (fetch_timeout ? K_TIMEOUT : K_RETIRE), e.kind);
                        check("illegal_flag", illegal_instr, (e.kind == K_ILLEGAL) ? 1 : 0);
                        check("timeout_flag", fetch_timeout, (e.kind == K_TIMEOUT) ? 1 : 0);
                    end
                end
                prev_req  = imem_req;
                prev_halt = halted;
            end
        end
    end

    initial begin
        reset      = 1'b0;
        run        = 1'b0;
        imem_valid = 1'b0;
        ir         = '0;
        #12;
        check("init_imem_req", imem_req, 0);
        check("init_alu_op", alu_op, 0);
        check("init_pc_en", pc_en, 0);
        check("init_we", regfile_write_enable, 0);
        check("init_halted", halted, 0);
        check("init_count", instr_count, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_without_run", imem_req, 0);
        run = 1'b1;

        do_instr(32'h002081B3, 0, 1'b0, 1'b0);
        do_instr(32'h407302B3, 0, 1'b0, 1'b0);
        do_instr(32'h00208033, 0, 1'b0, 1'b0);
        do_instr(32'h002081B3, 14, 1'b0, 1'b0);
        do_instr(32'h407302B3, 3, 1'b1, 1'b0);
        do_instr(32'h002081B3, 1, 1'b0, 1'b1);
        do_instr(32'h00000013, 0, 1'b0, 1'b0);
        do_instr(32'h40209033, 2, 1'b0, 1'b0);
        do_instr(32'h002081B3, 15, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            do_instr(rand_ir(),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(6, 15) : $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 15) == 0));
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
